// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares one single-port RAM between two requesters.
// Each granted request takes three cycles: the grant edge, one RAM access cycle, then an ack cycle.
//
// state  | meaning
// IDLE   | waiting for req0/req1; winner latched on the edge
// ACCESS | latched op presented to the RAM; read data captured on the edge
// DONE   | ack pulse to the owner; back to IDLE on the edge
module ram_arbiter #(
    parameter int BUS_WIDTH     = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     we0,
    input  logic [ADDRESS_WIDTH-1:0] ad0,
    input  logic [BUS_WIDTH-1:0]     X0,
    output logic                     ack0,
    output logic [BUS_WIDTH-1:0]     O0,
    input  logic                     req1,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] ad1,
    input  logic [BUS_WIDTH-1:0]     X1,
    output logic                     ack1,
    output logic [BUS_WIDTH-1:0]     O1,
    output logic [ADDRESS_WIDTH-1:0] ram_ad,
    output logic                     ram_st,
    output logic [BUS_WIDTH-1:0]     ram_X,
    input  logic [BUS_WIDTH-1:0]     ram_O
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                   state_q, state_d;
    logic                     prio_q, prio_d;
    logic                     owner_q, owner_d;
    logic                     lat_we_q, lat_we_d;
    logic [ADDRESS_WIDTH-1:0] lat_ad_q, lat_ad_d;
    logic [BUS_WIDTH-1:0]     lat_x_q, lat_x_d;
    logic                     ack0_q, ack0_d;
    logic                     ack1_q, ack1_d;
    logic [BUS_WIDTH-1:0]     o0_q, o0_d;
    logic [BUS_WIDTH-1:0]     o1_q, o1_d;
    logic                     winner;

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        lat_we_d = lat_we_q;
        lat_ad_d = lat_ad_q;
        lat_x_d  = lat_x_q;
        ack0_d   = ack0_q;
        ack1_d   = ack1_q;
        o0_d     = o0_q;
        o1_d     = o1_q;
        // prio only matters when both ports ask in the same cycle
        winner   = (req0 && req1) ? prio_q : req1;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d  = winner;
                    lat_we_d = winner ? we1 : we0;
                    lat_ad_d = winner ? ad1 : ad0;
                    lat_x_d  = winner ? X1  : X0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (!lat_we_q) begin
                    if (owner_q) o1_d = ram_O;
                    else         o0_d = ram_O;
                end
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                prio_d  = ~owner_q;
                state_d = DONE;
            end
            DONE: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            lat_we_q <= 1'b0;
            lat_ad_q <= '0;
            lat_x_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            o0_q     <= '0;
            o1_q     <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            lat_we_q <= lat_we_d;
            lat_ad_q <= lat_ad_d;
            lat_x_q  <= lat_x_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            o0_q     <= o0_d;
            o1_q     <= o1_d;
        end
    end

    // rst gates the store so a reset landing in ACCESS never commits the write
    assign ram_st = lat_we_q & (state_q == ACCESS) & ~rst;
    assign ram_ad = lat_ad_q;
    assign ram_X  = lat_x_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign O0     = o0_q;
    assign O1     = o1_q;

endmodule
